fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decode controller.
- Owns the program counter and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers one fetched word and presents it, with opcode/funct split out, to decode under a valid/ready handshake.
- Applies branch and jump redirects signalled by decode/execute on instruction accept, discarding any wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- ADDR_W, 32, PC/address width; fixed at 32 (jump-target formation depends on it).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request; held until granted
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid; at least 1 cycle after gnt, exactly once per grant
- imem_rdata  in  32  instruction word
- instr_valid  out  1  buffered instruction available
- dec_ready  in  1  decode accepts the instruction this cycle
- instr  out  32  buffered instruction
- instr_pc  out  32  address of instr
- opcode  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- br_taken  in  1  sampled only on accept: beq resolved taken
- jump  in  1  sampled only on accept: j instruction

Behaviour:
- Reset (async, rst_n=0):
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
  - State IDLE; discard=0; fetch_pc=RESET_PC.
- FSM states: IDLE, REQ, WAIT, FULL.
- IDLE -> REQ unconditionally on the first clock after reset release.
- REQ:
  - imem_req=1, imem_addr=fetch_pc.
  - On imem_gnt: record req_pc=fetch_pc, fetch_pc+=4, go to WAIT.
- WAIT:
  - On imem_rvalid with discard=0: instr<=imem_rdata, instr_pc<=req_pc, instr_valid<=1, go to FULL.
  - On imem_rvalid with discard=1: drop the data, clear discard, go to REQ.
- FULL:
  - Hold all outputs until accept (instr_valid & dec_ready).
  - On accept: clear instr_valid and go to REQ the same edge, so the next request is visible the cycle after accept.
- opcode and funct are pure slices of the registered instr.
- Redirect, evaluated only on accept:
  - pc4 = instr_pc+4.
  - jump=1: fetch_pc <= {pc4[31:28], instr[25:0], 2'b00}.
  - Else br_taken=1: fetch_pc <= pc4 + {{14{instr[15]}}, instr[15:0], 2'b00}; 32-bit arithmetic, wrap-around modulo 2^32, no overflow flag.
  - jump has priority over br_taken.
  - br_taken/jump while not accepting: ignored.
- Wrong-path discard: accept and redirect occur only in FULL, where no fetch is outstanding. discard is set only when the FSM is in REQ/WAIT with a stale address, which cannot occur with one outstanding request. The flag is retained for robustness: if set, the next response is dropped.
- Never more than one outstanding fetch; never a request while instr_valid=1.
- imem_rvalid outside WAIT: ignored; must not corrupt state.
- imem_gnt outside REQ: ignored.
- PC sequential wrap: 32'hFFFF_FFFC+4 -> 0.
- Reset mid-operation: all state cleared immediately. A response pending in memory for a pre-reset grant is the memory's responsibility; the block ignores rvalid until it has issued and been granted a request.
- Throughput: one instruction per 3 cycles minimum (req/gnt, rvalid, accept) with zero-wait memory.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_RTYPE, OP_J, OP_BEQ, ...), fetch FSM state enum, RESET_PC default, INSTR_W=32.
- Sub-module pc_target_calc: combinational branch/jump target from instr and instr_pc, reusable by execute.
- FSM and buffer stay in fetch_unit.

Test Plan:
1. Reset/sequential fetch: release rst_n, memory returns rdata=addr^32'hA5A5_0000 with 1-cycle latency, dec_ready=1 -> addresses 0,4,8,12 requested in order; instr_pc matches; opcode/funct equal slices.
2. Backpressure: hold dec_ready=0 for 5 cycles with instr at PC 8 -> instr/instr_pc stable; imem_req stays 0; after release, the next request is addr 12.
3. Branch: instr 32'h1000_FFFE (beq, imm -2) at PC 0x40, accept with br_taken=1 -> next imem_addr=0x3C. Same with imm 0x0003 -> 0x50.
4. Jump priority: instr 32'h0800_0010 at PC 0x4000_0000, jump=1 and br_taken=1 -> next imem_addr=0x4000_0040.
5. Grant/latency stalls: imem_gnt delayed 3 cycles, rvalid 4 cycles after gnt -> imem_addr stable during req; no second request; instr captured correctly. Spurious rvalid in FULL is ignored.
6. Async reset mid-WAIT: drop rst_n between gnt and rvalid -> outputs clear without a clock edge; after release, the first request is RESET_PC and the late rvalid is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the fetch stage and its neighbours.
//   - instruction / address widths and the default reset PC
//   - primary opcode constants (instr[31:26])
//   - fetch FSM state encoding
//   - small helpers that split an instruction word into its fields
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int          INSTR_W          = 32;
    localparam int          PC_W             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FULL = 2'd3
    } fetch_state_e;

    function automatic logic [5:0] instr_opcode(input logic [INSTR_W-1:0] w);
        return w[31:26];
    endfunction

    function automatic logic [5:0] instr_funct(input logic [INSTR_W-1:0] w);
        return w[5:0];
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// ---------------------------------------------------------------------------
// pc_target_calc
// Combinational control-flow target generation for an instruction at a
// known address. Shared between fetch (redirect on accept) and execute.
//
// Ports:
//   i_instr      in  32  instruction word
//   i_instr_pc   in  32  address of i_instr
//   o_pc4        out 32  i_instr_pc + 4
//   o_br_target  out 32  pc4 + sign-extended (imm16 << 2), wraps mod 2^32
//   o_j_target   out 32  {pc4[31:28], instr[25:0], 2'b00}
// ---------------------------------------------------------------------------
module pc_target_calc
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_instr_pc,
    output logic [PC_W-1:0]    o_pc4,
    output logic [PC_W-1:0]    o_br_target,
    output logic [PC_W-1:0]    o_j_target
);

    logic [PC_W-1:0] w_pc4;
    logic [PC_W-1:0] w_br_offset;

    assign w_pc4       = i_instr_pc + 32'd4;
    assign w_br_offset = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};

    assign o_pc4       = w_pc4;
    // Plain 32-bit add: a branch past either end of the address space wraps.
    assign o_br_target = w_pc4 + w_br_offset;
    // The jump keeps the 256 MB region of the delay-slot address (pc4), not
    // of the jump itself, so a jump in the last word of a region lands in
    // the next one.
    assign o_j_target  = {w_pc4[31:28], i_instr[25:0], 2'b00};

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage. Owns the PC, issues one outstanding request at a
// time to instruction memory (req/gnt/rvalid), buffers the returned word and
// hands it to decode under instr_valid/dec_ready. Branch/jump redirects are
// applied when decode accepts the buffered instruction.
//
// State table:
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | one cycle after reset release, nothing requested yet
//   REQ    | imem_req high at fetch_pc, waiting for imem_gnt
//   WAIT   | request granted, waiting for imem_rvalid
//   FULL   | instruction buffered and offered to decode
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req/imem_addr    request and word-aligned address (stable in REQ)
//   imem_gnt              request accepted this cycle
//   imem_rvalid/rdata     returned instruction word
//   instr_valid           buffered instruction available
//   dec_ready             decode takes the instruction this cycle
//   instr/instr_pc        buffered word and its address
//   opcode/funct          instr[31:26] / instr[5:0]
//   br_taken/jump         redirect qualifiers, looked at only on accept
// ---------------------------------------------------------------------------
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              dec_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    input  logic              br_taken,
    input  logic              jump
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;
    logic              r_discard;

    logic              w_grant;
    logic              w_resp;
    logic              w_accept;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_j_target;

    // Handshake events are qualified by state so that stray gnt/rvalid
    // pulses from memory can never move the datapath.
    assign w_grant    = (r_state == S_REQ)  && imem_gnt;
    assign w_resp     = (r_state == S_WAIT) && imem_rvalid;
    assign w_accept   = r_instr_valid && dec_ready;
    assign w_redirect = w_accept && (jump || br_taken);

    pc_target_calc u_pc_target_calc (
        .i_instr     (r_instr),
        .i_instr_pc  (r_instr_pc),
        .o_pc4       (w_pc4),
        .o_br_target (w_br_target),
        .o_j_target  (w_j_target)
    );

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state and request output
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = r_discard ? S_REQ : S_FULL;
                end
            end
            S_FULL: begin
                // Going straight back to REQ makes the next request visible
                // the cycle after accept.
                if (w_accept) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // PC and instruction buffer
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            // fetch_pc already points at the sequential successor once the
            // request is granted, so a non-redirecting accept leaves it alone.
            if (w_grant) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end else if (w_accept) begin
                if (jump) begin
                    r_fetch_pc <= w_j_target;
                end else if (br_taken) begin
                    r_fetch_pc <= w_br_target;
                end
            end

            if (w_resp && !r_discard) begin
                r_instr       <= imem_rdata;
                r_instr_pc    <= r_req_pc;
                r_instr_valid <= 1'b1;
            end else if (w_accept) begin
                r_instr_valid <= 1'b0;
            end

            // Accept only happens in FULL, so a redirect never meets an
            // in-flight fetch today. The flag is kept so that, should that
            // ever change, the stale response is dropped rather than issued.
            if (w_resp && r_discard) begin
                r_discard <= 1'b0;
            end else if (w_redirect && (r_state == S_REQ || r_state == S_WAIT)) begin
                r_discard <= 1'b1;
            end
        end
    end

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign opcode      = instr_opcode(r_instr);
    assign funct       = instr_funct(r_instr);

endmodule
